// File: rtl/prog_loader.sv
// prog_loader: streams a program image into the CPU RAM and holds the CPU
// core in reset until the whole image has been written.
//
// Stream format: LEN byte, then LEN x {HI, LO} byte pairs. LEN = 0 means
// 2^ADDR_W words. The pairs are packed into {HI, LO} words and written to
// consecutive RAM addresses starting at 0.
//
// Optional build macro PROG_LOADER_CHECKSUM_EN: a CHK byte follows the image.
// It must equal the XOR of all HI and LO bytes. On mismatch the loader parks
// in ERR with err=1 and keeps the CPU held.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      single-cycle load request (ignored while busy)
//   in_valid   in_data holds a valid byte
//   in_data    stream byte
//   in_ready   loader accepts a byte on this cycle's rising edge
//   ram_we     RAM write strobe, one cycle per word
//   ram_addr   RAM write address (holds its value between writes)
//   ram_wdata  RAM write data (holds its value between writes)
//   cpu_rst    active-low CPU hold, 0 = CPU held
//   busy       load in progress
//   done       image loaded, CPU released
//   err        checksum failure (constant 0 without the checksum build)
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so that a full 2^ADDR_W word image can be counted.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1'b1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK   = 3'd6,
    S_ERR   = 3'd7,
`endif
    S_DONE  = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  rem_r, idx_r, len_s;
  logic [7:0]        hi_r;
  logic              accept_s;
  logic              in_ready_r, ram_we_r, cpu_rst_r, busy_r, done_r;
  logic              in_ready_s, ram_we_s, cpu_rst_s, busy_s, done_s;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [DATA_W-1:0] ram_wdata_r;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] chk_r;
  logic       err_r, err_s;

  // Running checksum step: plain XOR of image bytes.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // in_ready is a registered copy of "state accepts bytes", so it is the handshake term.
  assign accept_s = in_valid & in_ready_r;
  assign len_s    = (in_data == 8'h00) ? CNT_FULL : CNT_W'(in_data);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (start) state_s = S_LEN; else state_s = S_IDLE;
      S_LEN:   if (accept_s) state_s = S_HI; else state_s = S_LEN;
      S_HI:    if (accept_s) state_s = S_LO; else state_s = S_HI;
      S_LO:    if (accept_s) state_s = S_WRITE; else state_s = S_LO;
      S_WRITE: begin
        if (rem_r == CNT_ONE) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_s = S_CHK;
`else
          state_s = S_DONE;
`endif
        end else begin
          state_s = S_HI;
        end
      end
      S_DONE:  if (start) state_s = S_LEN; else state_s = S_DONE;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept_s) begin
          if (in_data == chk_r) state_s = S_DONE; else state_s = S_ERR;
        end else begin
          state_s = S_CHK;
        end
      end
      S_ERR:   if (start) state_s = S_LEN; else state_s = S_ERR;
`endif
      default: state_s = S_IDLE;
    endcase
  end

  // Output values for the state being entered; registered below.
  always_comb begin
    in_ready_s = 1'b0;
    ram_we_s   = 1'b0;
    cpu_rst_s  = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    err_s      = 1'b0;
`endif
    case (state_s)
      S_LEN, S_HI, S_LO: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
      S_WRITE: begin
        busy_s   = 1'b1;
        // Guard: never strobe RAM with an index past the top address.
        ram_we_s = ~idx_r[ADDR_W];
      end
      S_DONE: begin
        done_s    = 1'b1;
        cpu_rst_s = 1'b1;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
      S_ERR:   err_s = 1'b1;
`endif
      default: busy_s = 1'b0;
    endcase
  end

  // State and output registers; reset forces every output low at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      in_ready_r <= 1'b0;
      ram_we_r   <= 1'b0;
      cpu_rst_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= in_ready_s;
      ram_we_r   <= ram_we_s;
      cpu_rst_r  <= cpu_rst_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  // Datapath: counters, byte latches, RAM address/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_r       <= {CNT_W{1'b0}};
      idx_r       <= {CNT_W{1'b0}};
      hi_r        <= 8'h00;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= {DATA_W{1'b0}};
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_r       <= 8'h00;
`endif
    end else begin
      case (state_r)
        S_LEN: begin
          if (accept_s) begin
            rem_r <= len_s;
            idx_r <= {CNT_W{1'b0}};
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_r <= 8'h00;
`endif
          end
        end
        S_HI: begin
          if (accept_s) begin
            hi_r  <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_r <= chk_fold(chk_r, in_data);
`endif
          end
        end
        S_LO: begin
          if (accept_s) begin
            ram_wdata_r <= DATA_W'({hi_r, in_data});
            ram_addr_r  <= idx_r[ADDR_W-1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_r       <= chk_fold(chk_r, in_data);
`endif
          end
        end
        S_WRITE: begin
          idx_r <= idx_r + CNT_ONE;
          rem_r <= rem_r - CNT_ONE;
        end
        default: begin
          // A restart clears the word index immediately.
          if (state_s == S_LEN) idx_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Error flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_r <= 1'b0;
    else      err_r <= err_s;
  end
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = in_ready_r;
  assign ram_we    = ram_we_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign cpu_rst   = cpu_rst_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Expected RAM writes are queued as the
// image is sent; a monitor pops and compares on every ram_we cycle.
module tb_prog_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, ram_we, cpu_rst, busy, done, err;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  logic [15:0] img[256];

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && ram_we) begin
      check("we_in_ready_low", 32'(in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", ram_addr, ram_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(mon_e[23:16]));
        check("wr_data", 32'(ram_wdata), 32'(mon_e[15:0]));
      end
    end
  end

  // Offer one byte until accepted; called and returns at a falling edge.
  task automatic send_byte(input logic [7:0] b, input bit toggle);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL byte_timeout: byte %0h never accepted", b);
    end
    @(negedge clk);
    if (toggle) begin
      in_valid = 1'b0;
      in_data  = 8'hEE;
      @(negedge clk);
    end
  endtask

  task automatic send_chk(input logic [7:0] x, input bit toggle);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(x, toggle);
`else
    x = x;
    toggle = toggle;
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_in_ready", 32'(in_ready), 32'd1);
    check("start_cpu_rst", 32'(cpu_rst), 32'd0);
    check("start_done", 32'(done), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    check("done", 32'(done), 32'd1);
    check("done_cpu_rst", 32'(cpu_rst), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_err", 32'(err), 32'd0);
    check("writes_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_load(input logic [7:0] len, input int n, input bit toggle, input int budget);
    logic [7:0] x = 8'h00;
    pulse_start();
    send_byte(len, toggle);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({8'(k), img[k]});
      send_byte(img[k][15:8], toggle);
      send_byte(img[k][7:0], toggle);
      x = x ^ img[k][15:8] ^ img[k][7:0];
    end
    send_chk(x, toggle);
    wait_done(budget);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Test 1: 02 12 34 AB CD, valid always high; done the cycle after last write
    img[0] = 16'h1234;
    img[1] = 16'hABCD;
    run_load(8'h02, 2, 1'b0, 1);

    // Test 2: same image with in_valid toggling
    run_load(8'h02, 2, 1'b1, 2);

    // Test 3: LEN=0 -> 256 words {k, ~k}
    for (int k = 0; k < 256; k++) img[k] = {8'(k), ~8'(k)};
    run_load(8'h00, 256, 1'b0, 1);
    check("full_last_data", 32'(ram_wdata), 32'hFF00);
    check("full_last_addr", 32'(ram_addr), 32'hFF);

    // Test 4: reset mid-load right after the first pair is taken
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    in_data = 8'h34;
    @(posedge clk);
    #1;
    check("pre_rst_we", 32'(ram_we), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("abort_ram_we", 32'(ram_we), 32'd0);
    check("abort_ram_addr", 32'(ram_addr), 32'd0);
    check("abort_ram_wdata", 32'(ram_wdata), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    img[0] = 16'h55AA;
    run_load(8'h01, 1, 1'b0, 2);

    // Test 5: start mid-load ignored, start in DONE restarts
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h01, 16'hABCD});
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midstart_busy", 32'(busy), 32'd1);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    send_chk(8'h40, 1'b0);
    wait_done(2);
    img[0] = 16'h7788;
    run_load(8'h01, 1, 1'b0, 2);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum match: 01 12 34 26
    img[0] = 16'h1234;
    run_load(8'h01, 1, 1'b0, 1);
    // Checksum mismatch: 01 12 34 00
    pulse_start();
    exp_q.push_back({8'h00, 16'h1234});
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h00, 1'b0);
    in_valid = 1'b0;
    check("chk_err", 32'(err), 32'd1);
    check("chk_done", 32'(done), 32'd0);
    check("chk_busy", 32'(busy), 32'd0);
    check("chk_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("chk_cpu_rst_held", 32'(cpu_rst), 32'd0);
    check("chk_err_sticky", 32'(err), 32'd1);
    pulse_start();
    check("chk_restart_err", 32'(err), 32'd0);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
